// File: rtl/escreveinstrucao_if.sv
// Byte-stream loader / instruction-fetch bundle for escreveinstrucao.
// master: program source + control unit (drives bytes, fim, PC, estado).
// slave : the loader itself (drives byte_ready, status, palavras, instrucao).
interface escreveinstrucao_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              fim;
  logic              carregando;
  logic              pronto;
  logic              erro;
  logic [ADDR_W-1:0] palavras;
  logic [31:0]       PC;
  logic [3:0]        estado;
  logic [31:0]       instrucao;

  modport master (
    output byte_in, byte_valid, fim, PC, estado,
    input  byte_ready, carregando, pronto, erro, palavras, instrucao
  );

  modport slave (
    input  byte_in, byte_valid, fim, PC, estado,
    output byte_ready, carregando, pronto, erro, palavras, instrucao
  );
endinterface

// File: rtl/escreveinstrucao.sv
// Purpose : assembles a LSB-first byte stream into 32-bit words, writes them to
//           a private instruction memory, then serves fetches at PC.
// Latency : 4 accepted bytes + 1 write cycle per word; fetch result 1 clk after
//           an edge with estado==4'b0000.
// Backpressure: byte_ready low for the single write cycle after every 4th byte,
//           and permanently once loading has finished or failed.
// Ports   : clk, rst_n (async active-low); bus = escreveinstrucao_if.slave
//           (byte_in/byte_valid/byte_ready, fim, carregando/pronto/erro,
//           palavras, PC/estado -> instrucao).
module escreveinstrucao #(
  parameter int          NUM_PALAVRAS = 18,
  parameter int          ADDR_W       = 5,
  parameter logic [31:0] NOP          = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  escreveinstrucao_if.slave    bus
);

  localparam int IDX_W = (NUM_PALAVRAS > 1) ? $clog2(NUM_PALAVRAS) : 1;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] RECEBE  = 3'd1;
  localparam logic [2:0] ESCREVE = 3'd2;
  localparam logic [2:0] PRONTO  = 3'd3;
  localparam logic [2:0] ERRO    = 3'd4;

  logic [2:0]        st_q;
  logic [1:0]        cnt_q;        // byte position inside the word being assembled
  logic [31:0]       asm_q;        // word assembly register
  logic [ADDR_W-1:0] palavras_q;   // words written == next write address
  logic              fim_pend_q;   // fim seen during ESCREVE, handled next cycle
  logic [31:0]       instr_q;

  logic [31:0]       mem [NUM_PALAVRAS];

  logic aceita;
  logic fim_ev;
  logic cheio;
  logic pc_ok;

  // byte_ready is forced low while reset is held, not just after it.
  assign bus.byte_ready = rst_n && ((st_q == OCIOSO) || (st_q == RECEBE));
  assign aceita         = bus.byte_valid && bus.byte_ready;
  assign fim_ev         = bus.fim || fim_pend_q;
  assign cheio          = (palavras_q == ADDR_W'(NUM_PALAVRAS));
  assign pc_ok          = (bus.PC < 32'(palavras_q));

  assign bus.carregando = (st_q == OCIOSO) || (st_q == RECEBE) || (st_q == ESCREVE);
  assign bus.pronto     = (st_q == PRONTO);
  assign bus.erro       = (st_q == ERRO);
  assign bus.palavras   = palavras_q;
  assign bus.instrucao  = instr_q;

  // Loader control. OCIOSO and RECEBE share one branch: in OCIOSO the byte
  // counter is always zero, so "fim with nothing pending" lands in PRONTO and
  // the first accepted byte moves on to RECEBE exactly as in RECEBE itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= OCIOSO;
      cnt_q      <= 2'd0;
      asm_q      <= 32'd0;
      palavras_q <= '0;
      fim_pend_q <= 1'b0;
    end else begin
      case (st_q)
        OCIOSO, RECEBE: begin
          if (fim_ev && aceita) begin
            // end-of-program and data on the same edge is a protocol violation
            st_q       <= ERRO;
            fim_pend_q <= 1'b0;
          end else if (fim_ev) begin
            st_q       <= (cnt_q == 2'd0) ? PRONTO : ERRO;
            fim_pend_q <= 1'b0;
          end else if (aceita) begin
            if (cheio) begin
              // memory already full: drop the byte, write nothing
              st_q <= ERRO;
            end else begin
              asm_q[8*cnt_q +: 8] <= bus.byte_in;
              cnt_q               <= cnt_q + 2'd1;
              st_q                <= (cnt_q == 2'd3) ? ESCREVE : RECEBE;
            end
          end
        end
        ESCREVE: begin
          palavras_q <= palavras_q + 1'b1;
          cnt_q      <= 2'd0;
          st_q       <= RECEBE;
          if (bus.fim) begin
            fim_pend_q <= 1'b1;
          end
        end
        PRONTO: begin
          st_q <= PRONTO;
        end
        default: begin
          st_q <= ERRO;
        end
      endcase
    end
  end

  // Memory is deliberately left out of reset so it maps onto plain RAM.
  // The write address is always < NUM_PALAVRAS: overflow is caught before
  // the fourth byte of a word can be accepted.
  always_ff @(posedge clk) begin
    if (st_q == ESCREVE) begin
      mem[palavras_q[IDX_W-1:0]] <= asm_q;
    end
  end

  // Fetch port. Only words actually written are ever read, so uninitialised
  // RAM never reaches instrucao; anything else returns NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP;
    end else if (st_q == PRONTO) begin
      if (bus.estado == 4'b0000) begin
        instr_q <= pc_ok ? mem[bus.PC[IDX_W-1:0]] : NOP;
      end
    end else begin
      instr_q <= NOP;
    end
  end

endmodule

// File: tb/tb_escreveinstrucao.sv
module tb_escreveinstrucao;
  localparam int          NW  = 18;
  localparam int          AW  = 5;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  escreveinstrucao_if #(.ADDR_W(AW)) bif ();

  escreveinstrucao #(.NUM_PALAVRAS(NW), .ADDR_W(AW), .NOP(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  // reference: bytes sent in order, words derived arithmetically
  logic [7:0]  sent [$];
  logic [31:0] words [NW];

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bif.byte_in    = 8'h00;
    bif.byte_valid = 1'b0;
    bif.fim        = 1'b0;
    bif.PC         = 32'd0;
    bif.estado     = 4'b0001;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sent.delete();
  endtask

  // Offers one byte and holds it until accepted; reports cycles spent waiting.
  task automatic send_byte(input logic [7:0] b, output int waits);
    waits = 0;
    bif.byte_in    = b;
    bif.byte_valid = 1'b1;
    @(negedge clk);
    while (!bif.byte_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (!bif.byte_ready) begin
      errors++;
      $display("FAIL ready_timeout byte=%h ready=%b required 1", b, bif.byte_ready);
    end
    @(posedge clk);
    #1;
    bif.byte_valid = 1'b0;
    sent.push_back(b);
  endtask

  task automatic pulse_fim();
    bif.fim = 1'b1;
    @(posedge clk);
    #1;
    bif.fim = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [3:0] est);
    bif.PC     = pc;
    bif.estado = est;
    @(posedge clk);
    #1;
    bif.estado = 4'b0001;
  endtask

  function automatic void build_words();
    for (int i = 0; i < NW; i++) begin
      words[i] = NOP;
      if (4 * i + 3 < sent.size())
        words[i] = sent[4*i] + (sent[4*i+1] * 256) + (sent[4*i+2] * 65536)
                 + (sent[4*i+3] * 16777216);
    end
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bif.byte_ready, bif.carregando, bif.pronto, bif.erro} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags got rdy/carr/pr/err=%b required 0100",
               {bif.byte_ready, bif.carregando, bif.pronto, bif.erro});
    end
    checks++;
    if (bif.palavras !== '0 || bif.instrucao !== NOP) begin
      errors++;
      $display("FAIL reset_values got palavras=%0d instr=%h required 0 %h",
               bif.palavras, bif.instrucao, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bif.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b required 1", bif.byte_ready);
    end
  endtask

  task automatic test_load_fetch();
    logic [7:0] prog [8];
    int w;
    prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    do_reset();
    foreach (prog[i]) send_byte(prog[i], w);
    @(posedge clk);
    #1;
    pulse_fim();
    checks++;
    if (bif.pronto !== 1'b1 || bif.carregando !== 1'b0 || bif.palavras !== AW'(2)) begin
      errors++;
      $display("FAIL load_done got pronto=%b carr=%b palavras=%0d required 1 0 2",
               bif.pronto, bif.carregando, bif.palavras);
    end
    fetch(32'd1, 4'b0000);
    checks++;
    if (bif.instrucao !== 32'h00A00593) begin
      errors++;
      $display("FAIL fetch_pc1 got %h required 00a00593", bif.instrucao);
    end
    fetch(32'd5, 4'b0000);
    checks++;
    if (bif.instrucao !== NOP) begin
      errors++;
      $display("FAIL fetch_pc5 got %h required %h", bif.instrucao, NOP);
    end
    fetch(32'd1, 4'b0000);
    fetch(32'd0, 4'b0011);
    checks++;
    if (bif.instrucao !== 32'h00A00593) begin
      errors++;
      $display("FAIL fetch_hold got %h required 00a00593", bif.instrucao);
    end
    fetch(32'd0, 4'b0000);
    checks++;
    if (bif.instrucao !== 32'h00500513) begin
      errors++;
      $display("FAIL fetch_pc0 got %h required 00500513", bif.instrucao);
    end
    fetch(32'hFFFF_FFF0, 4'b0000);
    checks++;
    if (bif.instrucao !== NOP) begin
      errors++;
      $display("FAIL fetch_pc_huge got %h required %h", bif.instrucao, NOP);
    end
  endtask

  task automatic test_partial_err();
    int w;
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), w);
    pulse_fim();
    checks++;
    if ({bif.erro, bif.pronto, bif.byte_ready, bif.carregando} !== 4'b1000) begin
      errors++;
      $display("FAIL partial_fim got err/pr/rdy/carr=%b required 1000",
               {bif.erro, bif.pronto, bif.byte_ready, bif.carregando});
    end
    bif.byte_valid = 1'b1;
    bif.byte_in    = 8'h5A;
    bif.estado     = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bif.erro !== 1'b1 || bif.palavras !== '0 || bif.instrucao !== NOP) begin
      errors++;
      $display("FAIL err_sticky got erro=%b palavras=%0d instr=%h required 1 0 %h",
               bif.erro, bif.palavras, bif.instrucao, NOP);
    end
  endtask

  task automatic test_collision();
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), w);
    @(posedge clk);
    #1;
    bif.byte_valid = 1'b1;
    bif.fim        = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (bif.erro !== 1'b1 || bif.pronto !== 1'b0 || bif.palavras !== AW'(1)) begin
      errors++;
      $display("FAIL fim_with_byte got erro=%b pronto=%b palavras=%0d required 1 0 1",
               bif.erro, bif.pronto, bif.palavras);
    end
  endtask

  task automatic test_overflow();
    int w;
    do_reset();
    for (int i = 0; i < 4 * NW; i++) send_byte(8'($urandom), w);
    @(posedge clk);
    #1;
    checks++;
    if (bif.palavras !== AW'(NW) || bif.erro !== 1'b0 || bif.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_mem got palavras=%0d erro=%b rdy=%b required %0d 0 1",
               bif.palavras, bif.erro, bif.byte_ready, NW);
    end
    send_byte(8'hEE, w);
    checks++;
    if (bif.erro !== 1'b1 || bif.palavras !== AW'(NW) || bif.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow got erro=%b palavras=%0d rdy=%b required 1 %0d 0",
               bif.erro, bif.palavras, bif.byte_ready, NW);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int nb = 32;
    do_reset();
    for (int i = 0; i < nb; i++) begin
      send_byte(8'($urandom), w);
      checks++;
      if (w !== ((i > 0 && i % 4 == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL stream_wait byte=%0d got %0d required %0d", i, w,
                 (i > 0 && i % 4 == 0) ? 1 : 0);
      end
    end
    @(posedge clk);
    #1;
    pulse_fim();
    build_words();
    for (int i = 0; i < nb / 4; i++) begin
      fetch(32'(i), 4'b0000);
      checks++;
      if (bif.instrucao !== words[i]) begin
        errors++;
        $display("FAIL stream_word idx=%0d got %h required %h", i, bif.instrucao, words[i]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int w;
    logic [7:0] a [6];
    logic [7:0] b [4];
    a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    do_reset();
    foreach (a[i]) send_byte(a[i], w);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.byte_ready !== 1'b0 || bif.palavras !== '0 || bif.carregando !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got rdy=%b palavras=%0d carr=%b required 0 0 1",
               bif.byte_ready, bif.palavras, bif.carregando);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sent.delete();
    foreach (b[i]) send_byte(b[i], w);
    @(posedge clk);
    #1;
    pulse_fim();
    checks++;
    if (bif.palavras !== AW'(1) || bif.pronto !== 1'b1) begin
      errors++;
      $display("FAIL reload got palavras=%0d pronto=%b required 1 1", bif.palavras, bif.pronto);
    end
    fetch(32'd0, 4'b0000);
    checks++;
    if (bif.instrucao !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL reload_word got %h required aabbccdd", bif.instrucao);
    end
    fetch(32'd1, 4'b0000);
    checks++;
    if (bif.instrucao !== NOP) begin
      errors++;
      $display("FAIL reload_pc1 got %h required %h", bif.instrucao, NOP);
    end
  endtask

  task automatic test_random();
    int w, n, gap;
    bit late;
    logic [31:0] pc;
    logic [3:0]  est;
    logic [31:0] exp_i;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = (r == 0) ? 0 : (r == 1) ? NW : $urandom_range(1, NW);
      for (int i = 0; i < 4 * n; i++) begin
        send_byte(8'($urandom), w);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      // fim right after the 4th byte of a word lands during the write cycle
      late = (n > 0) && (gap == 0) && $urandom_range(0, 1);
      if (!late) begin
        @(posedge clk);
        #1;
      end
      pulse_fim();
      if (late) begin
        checks++;
        if (bif.pronto !== 1'b0 || bif.carregando !== 1'b1) begin
          errors++;
          $display("FAIL fim_pending run=%0d got pronto=%b carr=%b required 0 1",
                   r, bif.pronto, bif.carregando);
        end
        @(posedge clk);
        #1;
      end
      checks++;
      if (bif.pronto !== 1'b1 || bif.erro !== 1'b0 || bif.palavras !== AW'(n)) begin
        errors++;
        $display("FAIL rand_done run=%0d got pronto=%b erro=%b palavras=%0d required 1 0 %0d",
                 r, bif.pronto, bif.erro, bif.palavras, n);
      end
      build_words();
      exp_i = NOP;
      for (int k = 0; k < 12; k++) begin
        pc  = 32'($urandom_range(0, NW + 3));
        est = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        fetch(pc, est);
        if (est == 4'b0000) exp_i = (pc < n) ? words[pc] : NOP;
        checks++;
        if (bif.instrucao !== exp_i) begin
          errors++;
          $display("FAIL rand_fetch run=%0d pc=%0d est=%h got %h required %h",
                   r, pc, est, bif.instrucao, exp_i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_partial_err();
    test_collision();
    test_overflow();
    test_back_to_back();
    test_reset_midload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
